mux_load_sched: RTL and testbench
=================================

# mux_load_sched

Round-robin scheduler that shares the 5-bit loadable counter datapath (2:1 input mux, load, count-enable) between two requesters. It grants one requester at a time, steers the mux select, issues a single-cycle load, then holds count-enable for a requester-specified number of cycles and signals completion. It sits directly above the mux/counter top and owns its `sel`, `load` and `enable` pins.

## Interface
- `LEN_W`, 4, width of run-length inputs (max run 2^LEN_W−1 cycles)
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-low
- `req_a`  in  1  requester A wants the datapath; held high until `done` or to abort
- `req_b`  in  1  requester B, same rules
- `len_a`  in  LEN_W  count-enable cycles for A; sampled at grant
- `len_b`  in  LEN_W  count-enable cycles for B; sampled at grant
- `sel`  out  1  mux select to datapath: 0 = A, 1 = B
- `load`  out  1  datapath load strobe, one cycle per grant
- `enable`  out  1  datapath count enable
- `gnt_a` / `gnt_b`  out  1 each  grant, one-hot or zero
- `done`  out  1  one-cycle completion pulse to granted requester
- `busy`  out  1  high in any state but IDLE

## Operation
- States: IDLE, LOAD, RUN, DONE (encoded in shared package).
- IDLE: all outputs 0 (`sel` holds last value). Any request -> LOAD; arbiter picks winner.
- Arbitration: 2-way round robin; `last` pointer = last granted. Both requesting -> grant the one not equal to `last`. Reset value of `last` = B, so A wins first contention.
- On grant: latch winner, latch its `len` into run counter, update `last`.
- LOAD: `gnt_x`=1, `sel`=winner, `load`=1. Next: len≠0 -> RUN; len=0 -> DONE.
- RUN: `gnt_x`=1, `enable`=1, run counter decrements each cycle; at counter=1 -> DONE. Exactly `len` enable cycles.
- DONE: `gnt_x`=1, `done`=1, `enable`=0 -> IDLE.
- Abort: granted requester's `req` low in LOAD or RUN -> IDLE next edge, no `done`, `enable` drops immediately next cycle; `last` keeps new value.
- `req` low during DONE ignored. Non-granted requester's `req` ignored until IDLE.
- `len` changes after grant ignored.

## Timing
- All outputs registered/Moore-decoded from state; no combinational input-to-output path.
- Request sampled at edge k -> `gnt`/`load` high in cycle k+1, first `enable` cycle k+2, `done` in cycle k+2+len, IDLE at k+3+len.
- Minimum turnaround between grants: 1 IDLE cycle (without B2B option).
- Reset (`rst`=0 at an edge), from any state incl. mid-RUN: state IDLE, `sel`=0, `load`=`enable`=`gnt_a`=`gnt_b`=`done`=`busy`=0, run counter 0, `last`=B.

## Configuration
- `MUX_SCHED_B2B_EN` defined: DONE transitions directly to LOAD when the other requester (or same, if other idle) is requesting, arbitrating with the same round-robin rule; no IDLE bubble, `busy` stays high.
- Undefined: DONE always -> IDLE; one idle cycle between grants.

## Structure
- Package `mux_sched_pkg`: state enum `sched_state_t`, `LEN_W` default, requester index constants `REQ_A`=0/`REQ_B`=1.
- Sub-module `rr_arb2`: 2-way round-robin arbiter (req[1:0], last pointer, update strobe -> one-hot winner); scheduler FSM and run counter stay in top.

## Test plan
- Reset mid-RUN: A granted len=6, assert `rst`=0 at 3rd enable cycle -> next cycle all outputs 0, `last`=B, no `done`.
- Single request: `req_a`=1, `len_a`=3 -> `gnt_a`+`load` 1 cycle, `sel`=0, `enable` exactly 3 cycles, `done` 1 cycle, then IDLE.
- Contention: `req_a`=`req_b`=1 from reset, len 2/2 -> A served first, then B (`sel`=1); held both -> A, B, A alternation.
- Zero length: `req_b`=1, `len_b`=0 -> LOAD then DONE, `enable` never asserted.
- Abort: A granted len=10, drop `req_a` after 4 enable cycles -> `enable` low next cycle, no `done`, B (pending) granted after IDLE.
- B2B (`MUX_SCHED_B2B_EN`): both requesting, len 1/1 -> `load` for B in cycle immediately after A's `done`, `busy` continuous; without macro one IDLE cycle between.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared definitions for the two-requester load/count scheduler:
// FSM state encoding, default run-length width and requester indices.
package mux_sched_pkg;

    localparam int DEF_LEN_W = 4;

    localparam int REQ_A = 0;
    localparam int REQ_B = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } sched_state_t;

endpackage

// File: rtl/mux_load_sched_if.sv
// Requester/datapath bundle of the scheduler.
// master: requester side (drives req/len); slave: scheduler side.
interface mux_load_sched_if #(
    parameter int LEN_W = mux_sched_pkg::DEF_LEN_W
);
    logic             req_a;
    logic             req_b;
    logic [LEN_W-1:0] len_a;
    logic [LEN_W-1:0] len_b;
    logic             sel;
    logic             load;
    logic             enable;
    logic             gnt_a;
    logic             gnt_b;
    logic             done;
    logic             busy;

    modport master (
        output req_a, req_b, len_a, len_b,
        input  sel, load, enable, gnt_a, gnt_b, done, busy
    );

    modport slave (
        input  req_a, req_b, len_a, len_b,
        output sel, load, enable, gnt_a, gnt_b, done, busy
    );
endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Holds the last-granted pointer (reset to B so
// A wins the first contention) and produces a one-hot winner combinationally.
module rr_arb2
    import mux_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] winner
);
    logic last_r;

    // Pick the requester that was not served last when both are asking.
    always_comb begin
        winner = 2'b00;
        case (req)
            2'b01:   winner = 2'b01;
            2'b10:   winner = 2'b10;
            2'b11:   winner = (last_r == 1'(REQ_A)) ? 2'b10 : 2'b01;
            default: winner = 2'b00;
        endcase
    end

    // Last-granted pointer, advanced on every grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_r <= 1'(REQ_B);
        end else if (update) begin
            last_r <= winner[REQ_B];
        end else begin
            last_r <= last_r;
        end
    end
endmodule

// File: rtl/mux_load_sched.sv
// Round-robin scheduler sharing the loadable counter datapath between two
// requesters: grant, one-cycle load, len cycles of enable, one-cycle done.
// Optional feature macro MUX_SCHED_B2B_EN: DONE may hand over straight to
// LOAD without an IDLE bubble.
module mux_load_sched
    import mux_sched_pkg::*;
#(
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic            clk,
    input  logic            rst,
    mux_load_sched_if.slave bus
);
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    sched_state_t     state_r, state_s;
    logic             win_r, win_s;
    logic [LEN_W-1:0] cnt_r, cnt_s, arb_len_s;
    logic [1:0]       req_s, arb_win_s;
    logic             grant_s, own_req_s;
    logic             sel_r, load_r, enable_r, gnt_a_r, gnt_b_r, done_r, busy_r;

    assign req_s     = {bus.req_b, bus.req_a};
    assign own_req_s = win_r ? bus.req_b : bus.req_a;
    assign arb_len_s = arb_win_s[REQ_B] ? bus.len_b : bus.len_a;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (req_s),
        .update (grant_s),
        .winner (arb_win_s)
    );

    // Next-state, grant capture and run-counter update.
    always_comb begin
        state_s = state_r;
        win_s   = win_r;
        cnt_s   = cnt_r;
        grant_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (|req_s) begin
                    grant_s = 1'b1;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (!own_req_s) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == CNT_ZERO) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!own_req_s) begin
                    state_s = ST_IDLE;
                end else begin
                    cnt_s   = cnt_r - CNT_ONE;
                    state_s = (cnt_r == CNT_ONE) ? ST_DONE : ST_RUN;
                end
            end
            ST_DONE: begin
`ifdef MUX_SCHED_B2B_EN
                if (|req_s) begin
                    grant_s = 1'b1;
                    state_s = ST_LOAD;
                end else begin
                    state_s = ST_IDLE;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            default: state_s = ST_IDLE;
        endcase
        // A grant latches the winner and its run length.
        if (grant_s) begin
            win_s = arb_win_s[REQ_B];
            cnt_s = arb_len_s;
        end else begin
            win_s = win_r;
        end
    end

    // State, winner and run-counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            win_r   <= 1'b0;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_s;
            win_r   <= win_s;
            cnt_r   <= cnt_s;
        end
    end

    // Output flops loaded from the next state so they track the FSM exactly.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sel_r    <= 1'b0;
            load_r   <= 1'b0;
            enable_r <= 1'b0;
            gnt_a_r  <= 1'b0;
            gnt_b_r  <= 1'b0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
        end else begin
            sel_r    <= grant_s ? win_s : sel_r;
            load_r   <= (state_s == ST_LOAD);
            enable_r <= (state_s == ST_RUN);
            done_r   <= (state_s == ST_DONE);
            busy_r   <= (state_s != ST_IDLE);
            gnt_a_r  <= (state_s != ST_IDLE) && !win_s;
            gnt_b_r  <= (state_s != ST_IDLE) && win_s;
        end
    end

    assign bus.sel    = sel_r;
    assign bus.load   = load_r;
    assign bus.enable = enable_r;
    assign bus.gnt_a  = gnt_a_r;
    assign bus.gnt_b  = gnt_b_r;
    assign bus.done   = done_r;
    assign bus.busy   = busy_r;
endmodule

// File: tb/tb_mux_load_sched.sv
// Bench for mux_load_sched: directed scenarios followed by random requester
// traffic, all checked cycle by cycle against a transaction-offset model.
module tb_mux_load_sched;
    import mux_sched_pkg::*;

    localparam int LW = DEF_LEN_W;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mux_load_sched_if #(.LEN_W(LW)) bus();

    mux_load_sched #(.LEN_W(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference: a grant starts a job; offset t counts cycles since grant
    // (t=1 load, t=2..len+1 enable, t=len+2 done).
    bit m_active;
    int m_who, m_len, m_t, m_last, m_sel;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_t      = 0;
        m_last   = 1;
        m_sel    = 0;
    endtask

    task automatic model_grant();
        bit ra, rb;
        ra = bus.req_a;
        rb = bus.req_b;
        if (ra || rb) begin
            if (ra && rb) m_who = (m_last == 0) ? 1 : 0;
            else          m_who = ra ? 0 : 1;
            m_last   = m_who;
            m_len    = (m_who == 1) ? int'(bus.len_b) : int'(bus.len_a);
            m_t      = 1;
            m_active = 1'b1;
            m_sel    = m_who;
        end
    endtask

    task automatic model_edge();
        bit own;
        if (!rst) begin
            model_reset();
        end else if (m_active) begin
            own = (m_who == 1) ? bus.req_b : bus.req_a;
            if (m_t <= m_len + 1 && !own) begin
                m_active = 1'b0;
            end else if (m_t == m_len + 2) begin
                m_active = 1'b0;
`ifdef MUX_SCHED_B2B_EN
                model_grant();
`endif
            end else begin
                m_t++;
            end
        end else begin
            model_grant();
        end
    endtask

    task automatic check_all();
        check("gnt_a",  bus.gnt_a,  32'(m_active && m_who == 0));
        check("gnt_b",  bus.gnt_b,  32'(m_active && m_who == 1));
        check("load",   bus.load,   32'(m_active && m_t == 1));
        check("enable", bus.enable, 32'(m_active && m_t >= 2 && m_t <= m_len + 1));
        check("done",   bus.done,   32'(m_active && m_t == m_len + 2));
        check("busy",   bus.busy,   32'(m_active));
        check("sel",    bus.sel,    32'(m_sel));
    endtask

    // One clock: model sees the same inputs as the DUT edge, then compare.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
    endtask

    task automatic run_until_done(input int who, input int max, output int ens, output bit seen);
        ens  = 0;
        seen = 1'b0;
        for (int i = 0; i < max && !seen; i++) begin
            cycle();
            if (bus.enable && ((who == 0) ? bus.gnt_a : bus.gnt_b)) ens++;
            if (bus.done && ((who == 0) ? bus.gnt_a : bus.gnt_b)) seen = 1'b1;
        end
    endtask

    initial begin
        int  ens;
        bit  seen;
        int  order[$];
        int  a_done, b_load;

        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.len_a = '0;
        bus.len_b = '0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle();
        cycle();
        rst = 1'b1;

        // Single request, len 3.
        bus.req_a = 1'b1;
        bus.len_a = 4'd3;
        run_until_done(0, 20, ens, seen);
        check("single_done_seen", 32'(seen), 32'd1);
        check("single_enable_cycles", 32'(ens), 32'd3);
        bus.req_a = 1'b0;
        cycle();
        cycle();

        // Contention from reset, both held: A, B, A.
        do_reset();
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        bus.len_a = 4'd2;
        bus.len_b = 4'd2;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (bus.load) order.push_back(int'(bus.sel));
        end
        check("contention_grants", 32'(order.size() >= 3), 32'd1);
        if (order.size() >= 3) begin
            check("contention_1st", 32'(order[0]), 32'd0);
            check("contention_2nd", 32'(order[1]), 32'd1);
            check("contention_3rd", 32'(order[2]), 32'd0);
        end
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        cycle();
        cycle();

        // Zero-length job for B.
        bus.req_b = 1'b1;
        bus.len_b = 4'd0;
        run_until_done(1, 10, ens, seen);
        check("zero_done_seen", 32'(seen), 32'd1);
        check("zero_enable_cycles", 32'(ens), 32'd0);
        bus.req_b = 1'b0;
        cycle();

        // Abort of A after 4 enable cycles, B pending.
        do_reset();
        bus.req_a = 1'b1;
        bus.len_a = 4'd10;
        bus.req_b = 1'b1;
        bus.len_b = 4'd2;
        ens = 0;
        for (int i = 0; i < 20 && ens < 4; i++) begin
            cycle();
            if (bus.enable && bus.gnt_a) ens++;
        end
        check("abort_reached_4", 32'(ens), 32'd4);
        bus.req_a = 1'b0;
        cycle();
        check("abort_enable_low", bus.enable, 32'd0);
        check("abort_no_done", bus.done, 32'd0);
        run_until_done(1, 15, ens, seen);
        check("abort_b_served", 32'(seen), 32'd1);
        bus.req_b = 1'b0;
        cycle();

        // Reset in the 3rd enable cycle of a len 6 job.
        bus.req_a = 1'b1;
        bus.len_a = 4'd6;
        ens = 0;
        for (int i = 0; i < 20 && ens < 3; i++) begin
            cycle();
            if (bus.enable) ens++;
        end
        check("rstmid_reached_3", 32'(ens), 32'd3);
        rst = 1'b0;
        cycle();
        check("rstmid_no_done", bus.done, 32'd0);
        check("rstmid_busy", bus.busy, 32'd0);
        rst = 1'b1;
        bus.req_a = 1'b0;
        cycle();
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        cycle();
        check("rstmid_last_b_a_wins", bus.gnt_a, 32'd1);
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        cycle();
        cycle();

        // Handover gap between A's done and B's load.
        do_reset();
        bus.req_a = 1'b1;
        bus.req_b = 1'b1;
        bus.len_a = 4'd1;
        bus.len_b = 4'd1;
        a_done = -1;
        b_load = -1;
        for (int i = 0; i < 20 && b_load < 0; i++) begin
            cycle();
            if (bus.done && bus.gnt_a && a_done < 0) begin
                a_done = i;
                bus.req_a = 1'b0;
            end
            if (bus.load && bus.gnt_b) b_load = i;
        end
`ifdef MUX_SCHED_B2B_EN
        check("handover_gap", 32'(b_load - a_done), 32'd1);
`else
        check("handover_gap", 32'(b_load - a_done), 32'd2);
`endif
        bus.req_b = 1'b0;
        cycle();
        cycle();

        // Random requester traffic.
        for (int i = 0; i < 3000; i++) begin
            if (!bus.req_a) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.req_a = 1'b1;
                    bus.len_a = 4'($urandom_range(0, 15) == 0 ? 15 : $urandom_range(0, 6));
                end
            end else if (bus.done && bus.gnt_a) begin
                bus.req_a = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                bus.req_a = 1'b0;
            end else begin
                bus.len_a = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : bus.len_a;
            end
            if (!bus.req_b) begin
                if ($urandom_range(0, 3) == 0) begin
                    bus.req_b = 1'b1;
                    bus.len_b = 4'($urandom_range(0, 15) == 0 ? 15 : $urandom_range(0, 6));
                end
            end else if (bus.done && bus.gnt_b) begin
                bus.req_b = 1'b0;
            end else if ($urandom_range(0, 49) == 0) begin
                bus.req_b = 1'b0;
            end else begin
                bus.len_b = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : bus.len_b;
            end
            rst = ($urandom_range(0, 199) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
